// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: 32 shift-add / restoring-divide steps (33-cycle latency, 1 for special cases).
// Holds the pipeline via stall while busy; result is a single-cycle rsp_valid pulse with no downstream backpressure.
module ex_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;         // lo (multiply) or Q (divide)
  logic [31:0] b_q, b_d;         // |rs2|
  logic [31:0] hi_q, hi_d;       // hi (multiply) or R (divide)
  logic        neg_q, neg_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        rs1_sgn, rs2_sgn, s1, s2, is_div, is_rem, ovf, special, neg_in;
  logic [31:0] mag1, mag2, special_val;
  logic [32:0] mul_sum, div_sh;
  logic [31:0] mul_hi, mul_lo, div_r, div_q, div_res, div_out;
  logic [63:0] product, prod_out;
  logic        div_ge;

  always_comb begin
    rs1_sgn = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    rs2_sgn = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    s1      = rs1_sgn & req_rs1[31];
    s2      = rs2_sgn & req_rs2[31];
    mag1    = s1 ? (32'd0 - req_rs1) : req_rs1;
    mag2    = s2 ? (32'd0 - req_rs2) : req_rs2;
    is_div  = req_op[2];
    is_rem  = req_op[2] & req_op[1];
    // s1/s2 are already zero for unsigned operands, so this covers every op
    neg_in  = is_rem ? s1 : (s1 ^ s2);
    ovf     = is_div && !req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    special = is_div && ((req_rs2 == 32'd0) || ovf);
    if (req_rs2 == 32'd0) special_val = is_rem ? req_rs1 : 32'hFFFF_FFFF;
    else                  special_val = is_rem ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : 33'd0);
    mul_hi   = mul_sum[32:1];
    mul_lo   = {mul_sum[0], a_q[31:1]};
    product  = {mul_hi, mul_lo};
    prod_out = neg_q ? (64'd0 - product) : product;

    div_sh   = {hi_q, a_q[31]};
    div_ge   = div_sh >= {1'b0, b_q};
    // the remainder after subtraction is always below |rs2|, so 32 bits hold it
    div_r    = div_ge ? (div_sh[31:0] - b_q) : div_sh[31:0];
    div_q    = {a_q[30:0], div_ge};
    div_res  = op_q[1] ? div_r : div_q;
    div_out  = neg_q ? (32'd0 - div_res) : div_res;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    neg_d      = neg_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          op_d  = req_op;
          a_d   = mag1;
          b_d   = mag2;
          hi_d  = 32'd0;
          neg_d = neg_in;
          cnt_d = 5'd0;
          if (special) begin
            state_d    = DONE;
            rsp_data_d = special_val;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          hi_d = div_r;
          a_d  = div_q;
        end else begin
          hi_d = mul_hi;
          a_d  = mul_lo;
        end
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          if (op_q[2])            rsp_data_d = div_out;
          else if (op_q == 3'd0)  rsp_data_d = prod_out[31:0];
          else                    rsp_data_d = prod_out[63:32];
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      hi_q       <= 32'd0;
      neg_q      <= 1'b0;
      rsp_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      neg_q      <= neg_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign stall     = ((state_q == IDLE) && req_valid && !flush) || (state_q == CALC);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE) && !flush;
  assign rsp_data  = rsp_data_q;

endmodule
